// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus issue sequencer that feeds an async transmitter through its start/data/busy handshake.
//   Parameters: DEPTH FIFO entries (power of 2, >=2), AW = log2(DEPTH).
//   Optional feature: define UART_TX_CRLF_EN to send 8'h0D ahead of every stored 8'h0A.
//   Ports:
//     clk_i        system clock (same clock as the transmitter)
//     rstn_i       synchronous active-low reset
//     wr_en_i      push wr_data_i this cycle
//     wr_data_i    byte to push
//     full_o       occupancy == DEPTH
//     empty_o      occupancy == 0
//     count_o      occupancy, 0..DEPTH
//     overflow_o   one-cycle pulse after a push attempted while full (byte dropped)
//     idle_o       nothing queued, sequencer idle, transmitter not busy
//     tx_start_o   registered one-cycle start pulse to the transmitter
//     tx_data_o    registered byte to the transmitter, held until the next issue
//     tx_busy_i    transmitter busy
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          wr_en_i,
    input  logic [7:0]    wr_data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          overflow_o,
    output logic          idle_o,
    output logic          tx_start_o,
    output logic [7:0]    tx_data_o,
    input  logic          tx_busy_i
);
    typedef enum logic [1:0] {S_IDLE, S_WAITHI, S_WAITLO} state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    state_t        state_q, state_d;
    logic          push, pop;
    logic [7:0]    head;
`ifdef UART_TX_CRLF_EN
    logic          crlf_q, crlf_d;
`endif

    assign head       = mem_q[rd_ptr_q];
    assign full_o     = count_q == (AW+1)'(DEPTH);
    assign empty_o    = count_q == '0;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign idle_o     = empty_o && state_q == S_IDLE && !tx_busy_i;
    // full is the pre-edge value, so a push coinciding with a pop at full is still rejected
    assign push       = wr_en_i && !full_o;
    assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
        crlf_d     = crlf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty_o && !tx_busy_i) begin
                    tx_start_d = 1'b1;
                    state_d    = S_WAITHI;
`ifdef UART_TX_CRLF_EN
                    // a LF at the head first produces a CR and stays queued; the flag releases it next time
                    if (head == 8'h0A && !crlf_q) begin
                        tx_data_d = 8'h0D;
                        crlf_d    = 1'b1;
                    end else begin
                        tx_data_d = head;
                        pop       = 1'b1;
                        crlf_d    = 1'b0;
                    end
`else
                    tx_data_d = head;
                    pop       = 1'b1;
`endif
                end
            end
            S_WAITHI: state_d = tx_busy_i ? S_WAITLO : S_WAITHI;
            S_WAITLO: state_d = tx_busy_i ? S_WAITLO : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            state_q    <= S_IDLE;
`ifdef UART_TX_CRLF_EN
            crlf_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_q + AW'(push);
            rd_ptr_q   <= rd_ptr_q + AW'(pop);
            count_q    <= count_d;
            overflow_q <= wr_en_i && full_o;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            state_q    <= state_d;
`ifdef UART_TX_CRLF_EN
            crlf_q     <= crlf_d;
`endif
        end
    end
endmodule
